div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the EX stage beside the ALU.
- Produces the div_done / busy status the hazard-detection unit uses to hold PC, IF/ID and ID/EX while a division is in flight.
- Result is written into the EX/MEM path in the cycle div_done is high.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and >= 4.
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  EX-stage instruction is a divide (is_div); sampled only in IDLE.
- flush  input  1  pipeline flush; aborts any operation.
- op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  input  WIDTH  rs1 value.
- divisor  input  WIDTH  rs2 value.
- result  output  WIDTH  quotient or remainder per op, registered.
- div_done  output  1  result valid; high exactly one cycle per operation.
- busy  output  1  high in BUSY state.

Behaviour:
- One clock domain; reset is synchronous and active-low (rst_n sampled on rising clk).
- Reset: state=IDLE; result=0; div_done=0; busy=0; counter=0; internal quotient/remainder regs=0.
- States: IDLE, BUSY, DONE.
  - div_done = (state==DONE).
  - busy = (state==BUSY).
- IDLE:
  - If start=1 and flush=0, capture op, sign flags and operand magnitudes.
  - Signed ops (00, 10) take magnitudes of negative operands; unsigned ops use raw operands.
  - Normal case: clear remainder, load quotient reg with |dividend|, counter=0, go to BUSY.
  - Special case: divisor==0, or signed op with dividend==1<<(WIDTH-1) and divisor==all-ones. Handling is defined under Optional Feature.
- BUSY, one step per cycle:
  - Shift {rem,quo} left by 1.
  - Trial subtract: rem_shifted - |divisor| in WIDTH+1 bits.
  - If non-negative, keep the difference and set quo LSB=1; otherwise restore and set LSB=0.
  - counter++.
  - On the step where counter==WIDTH-1, apply sign fixup and register result, then go to DONE.
    - Quotient is negated if signed and sign(dividend)!=sign(divisor).
    - Remainder takes the sign of the dividend.
- DONE: hold div_done=1 for one cycle, ignore start, go to IDLE.
  - In this cycle start is still high for the same instruction; it must not restart.
- Latency (normal): start sampled at edge E0; div_done high in the cycle after edge E(WIDTH), i.e. WIDTH cycles after acceptance.
- Hazard interface: div_done is the only completion indication; a hazard unit stalling on start && !div_done releases the pipeline exactly on the DONE cycle.
- Back-to-back divides: a second divide arriving in the cycle after DONE is accepted normally in IDLE.
- result holds its value until the next result is registered; it is not cleared by flush.
- Special-case results:
  - divisor==0: DIV/DIVU quotient = all-ones; REM/REMU = dividend.
  - Signed overflow: DIV result = 1<<(WIDTH-1); REM result = 0.
- flush=1 in any state: next state IDLE, counter=0, no div_done pulse. flush has priority over start.
- rst_n=0 mid-operation: all state returns to reset values at that edge; no div_done.

Optional Feature:
- Macro DIV_FAST_SPECIAL_EN.
- Defined: the special cases skip BUSY. Result is registered at E0, state goes IDLE->DONE, and div_done is high one cycle after acceptance.
- Undefined: special cases run the full WIDTH-step BUSY sequence with the same latency as normal operations. The special-case results above are forced at the final step, so result values are identical either way.

Test Plan:
- DIV 100 / 7, start held until div_done -> result=14; div_done one-cycle pulse 32 cycles after acceptance; busy high 32 cycles.
- REM -100 / 7 (0xFFFFFF9C, 7) -> result=0xFFFFFFFE (-2); DIV same operands -> 0xFFFFFFF2 (-14); DIVU 0xFFFFFFFF / 2 -> 0x7FFFFFFF; REMU 0xFFFFFFFF / 2 -> 1.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0; DIVU 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5. Latency is 1 cycle with DIV_FAST_SPECIAL_EN and 32 cycles without.
- Back-to-back: DIV 50/5 then DIVU 9/3 with start high continuously -> div_done pulses with results 10 then 3; second acceptance in the cycle after the first DONE; no spurious third operation.
- Abort: flush at BUSY cycle 10 -> IDLE next cycle, no div_done, result unchanged. A following DIV 21/4 -> 5.
- Reset: rst_n=0 at BUSY cycle 5 -> next cycle busy=0, div_done=0, result=0. A new operation after release behaves normally.

Source files
------------

// File: rtl/div_unit_if.sv
// div_unit_if: EX-stage divide handshake and data bus.
// master = issuing side (EX stage / testbench), slave = div_unit.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             flush;
    logic [1:0]       op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] result;
    logic             div_done;
    logic             busy;

    modport master (
        output start, flush, op, dividend, divisor,
        input  result, div_done, busy
    );

    modport slave (
        input  start, flush, op, dividend, divisor,
        output result, div_done, busy
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow
// bypass the iteration and complete one cycle after acceptance.
//
// state | meaning
// IDLE  | waiting for start; captures operands on acceptance
// BUSY  | one restoring step per cycle, WIDTH steps total
// DONE  | result valid, div_done high for this single cycle
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic       clk,
    input logic       rst_n,
    div_unit_if.slave bus
);

`ifdef DIV_FAST_SPECIAL_EN
    localparam bit FAST_SPECIAL = 1'b1;
`else
    localparam bit FAST_SPECIAL = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
    logic [WIDTH-1:0] result_q, special_res_q;
    logic             op_rem_q, neg_quo_q, neg_rem_q, special_q;
    logic             div_done_c, busy_c;

    // operand conditioning at acceptance
    logic             signed_op, dvd_neg, dvs_neg, div_zero, ovf, special_in;
    logic [WIDTH-1:0] dvd_mag, dvs_mag, special_val;

    assign signed_op  = ~bus.op[0];
    assign dvd_neg    = signed_op & bus.dividend[WIDTH-1];
    assign dvs_neg    = signed_op & bus.divisor[WIDTH-1];
    assign dvd_mag    = dvd_neg ? -bus.dividend : bus.dividend;
    assign dvs_mag    = dvs_neg ? -bus.divisor  : bus.divisor;
    assign div_zero   = (bus.divisor == '0);
    assign ovf        = signed_op && (bus.dividend == MIN_NEG) && (bus.divisor == '1);
    assign special_in = div_zero | ovf;
    assign special_val = div_zero ? (bus.op[1] ? bus.dividend : '1)
                                  : (bus.op[1] ? '0 : MIN_NEG);

    // one restoring step; since rem < divisor, rem_sh < 2*divisor so a
    // WIDTH+1 bit difference carries the borrow in its top bit
    logic [WIDTH:0]   rem_sh, diff;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_nx, quo_nx, quo_fix, rem_fix, final_val;

    assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
    assign diff      = rem_sh - {1'b0, dvsr_q};
    assign trial_ok  = ~diff[WIDTH];
    assign rem_nx    = trial_ok ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nx    = {quo_q[WIDTH-2:0], trial_ok};
    assign quo_fix   = neg_quo_q ? -quo_nx : quo_nx;
    assign rem_fix   = neg_rem_q ? -rem_nx : rem_nx;
    assign final_val = special_q ? special_res_q : (op_rem_q ? rem_fix : quo_fix);

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next-state and status outputs; flush overrides everything
    always_comb begin
        state_d    = state_q;
        div_done_c = 1'b0;
        busy_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = (FAST_SPECIAL && special_in) ? DONE : BUSY;
            end
            BUSY: begin
                busy_c = 1'b1;
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                div_done_c = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush) state_d = IDLE;
    end

    // datapath: operand capture, iteration, result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvsr_q        <= '0;
            result_q      <= '0;
            special_res_q <= '0;
            op_rem_q      <= 1'b0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            special_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        op_rem_q      <= bus.op[1];
                        neg_quo_q     <= dvd_neg ^ dvs_neg;
                        neg_rem_q     <= dvd_neg;
                        rem_q         <= '0;
                        quo_q         <= dvd_mag;
                        dvsr_q        <= dvs_mag;
                        cnt_q         <= '0;
                        special_q     <= special_in;
                        special_res_q <= special_val;
                        if (FAST_SPECIAL && special_in) result_q <= special_val;
                    end
                end
                BUSY: begin
                    if (bus.flush) begin
                        cnt_q <= '0;
                    end else begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST) result_q <= final_val;
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    assign bus.result   = result_q;
    assign bus.div_done = div_done_c;
    assign bus.busy     = busy_c;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized checks of div_unit against an
// arithmetic reference model of the RV32M divide/remainder rules.
module tb_div_unit;
    localparam int WIDTH = 32;

`ifdef DIV_FAST_SPECIAL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(WIDTH)) bus ();

    div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RV32M results computed with plain SV arithmetic
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa, sb;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
            sa = a;
            sb = b;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    // edges after the accepting edge until div_done is visible
    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        bit special;
        special = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (special && FAST) ? 0 : WIDTH;
    endfunction

    // drive one operation with start held until div_done, then one more edge
    // (start still high) so the caller can see DONE did not restart
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_cnt,
                          output logic post_busy, output logic post_done);
        bus.op       = op;
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        lat          = -1;
        busy_cnt     = 0;
        res          = 'x;
        post_busy    = 1'bx;
        post_done    = 1'bx;
        for (int cyc = 0; cyc < WIDTH + 8; cyc++) begin
            @(posedge clk); #1;
            if (bus.busy) busy_cnt++;
            if (bus.div_done) begin
                lat = cyc;
                res = bus.result;
                break;
            end
        end
        if (lat >= 0) begin
            @(posedge clk); #1;
            post_busy = bus.busy;
            post_done = bus.div_done;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'd0;
        bus.dividend = '0; bus.divisor = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", bus.result); end
        total++; if (bus.div_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.div_done); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [1:0]  d_op  [9] = '{2'd0, 2'd2, 2'd0, 2'd1, 2'd3, 2'd0, 2'd2, 2'd1, 2'd2};
        logic [31:0] d_a   [9] = '{32'd100, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'hFFFF_FFFF,
                                   32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5};
        logic [31:0] d_b   [9] = '{32'd7, 32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFF,
                                   32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] d_exp [9] = '{32'd14, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 32'h7FFF_FFFF,
                                   32'd1, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd5};
        logic [31:0] res;
        int lat, bcnt, elat;
        logic pb, pd;
        for (int i = 0; i < 9; i++) begin
            elat = ref_latency(d_op[i], d_a[i], d_b[i]);
            run_op(d_op[i], d_a[i], d_b[i], res, lat, bcnt, pb, pd);
            bus.start = 1'b0;
            total++; if (res !== d_exp[i]) begin bad++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, d_exp[i]); end
            total++; if (lat != elat) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, elat); end
            total++; if (bcnt != elat) begin bad++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, bcnt, elat); end
            total++; if (pb !== 1'b0) begin bad++; $display("FAIL dir%0d_restart_busy got=%b exp=0", i, pb); end
            total++; if (pd !== 1'b0) begin bad++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, pd); end
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, res, exp;
        int lat, bcnt, elat, kind;
        logic pb, pd;
        for (int i = 0; i < 24; i++) begin
            op   = 2'($urandom_range(0, 3));
            a    = $urandom;
            kind = $urandom_range(0, 9);
            if (kind == 0)      b = 32'd0;
            else if (kind == 1) b = 32'($urandom_range(1, 15));
            else if (kind == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else                b = $urandom >> $urandom_range(0, 31);
            exp  = ref_result(op, a, b);
            elat = ref_latency(op, a, b);
            run_op(op, a, b, res, lat, bcnt, pb, pd);
            bus.start = 1'b0;
            total++; if (res !== exp) begin bad++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, res, exp); end
            total++; if (lat != elat) begin bad++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, elat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int lat, bcnt, extra;
        logic pb, pd;
        run_op(2'd0, 32'd50, 32'd5, res, lat, bcnt, pb, pd);
        total++; if (res !== 32'd10) begin bad++; $display("FAIL b2b_first_result got=%h exp=%h", res, 32'd10); end
        total++; if (pb !== 1'b0) begin bad++; $display("FAIL b2b_done_restart got=%b exp=0", pb); end
        run_op(2'd1, 32'd9, 32'd3, res, lat, bcnt, pb, pd);
        bus.start = 1'b0;
        total++; if (res !== 32'd3) begin bad++; $display("FAIL b2b_second_result got=%h exp=%h", res, 32'd3); end
        total++; if (lat != WIDTH) begin bad++; $display("FAIL b2b_second_accept_latency got=%0d exp=%0d", lat, WIDTH); end
        extra = 0;
        repeat (WIDTH + 4) begin
            @(posedge clk); #1;
            if (bus.busy || bus.div_done) extra++;
        end
        total++; if (extra != 0) begin bad++; $display("FAIL b2b_no_third_op active_cycles got=%0d exp=0", extra); end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat, bcnt, dones;
        logic pb, pd, busy_at10;
        bus.op = 2'd0; bus.dividend = 32'd1000; bus.divisor = 32'd3; bus.start = 1'b1;
        busy_at10 = 1'b0;
        for (int cyc = 0; cyc <= 10; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 10) busy_at10 = bus.busy;
        end
        total++; if (busy_at10 !== 1'b1) begin bad++; $display("FAIL flush_busy_before got=%b exp=1", busy_at10); end
        bus.flush = 1'b1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_busy_after got=%b exp=0", bus.busy); end
        total++; if (bus.result !== 32'd3) begin bad++; $display("FAIL flush_result_held got=%h exp=%h", bus.result, 32'd3); end
        bus.flush = 1'b0;
        dones = 0;
        repeat (WIDTH + 4) begin
            @(posedge clk); #1;
            if (bus.div_done) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL flush_no_done got=%0d exp=0", dones); end
        bus.start = 1'b1; bus.flush = 1'b1; bus.dividend = 32'd8; bus.divisor = 32'd2;
        @(posedge clk); #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_over_start got=%b exp=0", bus.busy); end
        bus.flush = 1'b0;
        run_op(2'd0, 32'd21, 32'd4, res, lat, bcnt, pb, pd);
        bus.start = 1'b0;
        total++; if (res !== 32'd5) begin bad++; $display("FAIL flush_followup_result got=%h exp=%h", res, 32'd5); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res, exp;
        int lat, bcnt;
        logic pb, pd;
        bus.op = 2'd0; bus.dividend = 32'h0001_2345; bus.divisor = 32'd23; bus.start = 1'b1;
        for (int cyc = 0; cyc <= 5; cyc++) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        bus.start = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        total++; if (bus.div_done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", bus.div_done); end
        total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL rstmid_result got=%h exp=0", bus.result); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp = ref_result(2'd3, 32'd1000, 32'd7);
        run_op(2'd3, 32'd1000, 32'd7, res, lat, bcnt, pb, pd);
        bus.start = 1'b0;
        total++; if (res !== exp) begin bad++; $display("FAIL rstmid_followup_result got=%h exp=%h", res, exp); end
        total++; if (lat != WIDTH) begin bad++; $display("FAIL rstmid_followup_latency got=%0d exp=%0d", lat, WIDTH); end
    endtask

    initial begin
        bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'd0;
        bus.dividend = '0; bus.divisor = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
